voice_frame_collector: RTL and testbench

- Upstream neighbour of the 32-voice mixer.
- Each audio frame, it polls a time-multiplexed voice generator one voice at a time and captures each 16-bit voice sample.
- It packs the captured samples into a 512-bit frame and presents it with a one-cycle samples_ready pulse.
- The output frame is double-buffered, so the mixer always sees a stable, complete frame.

---
 rtl/voice_frame_collector_pkg.sv | 17 +
 rtl/voice_wait_timer.sv | 31 +++
 rtl/voice_frame_collector.sv | 140 ++++++++++++++
 tb/tb_voice_frame_collector.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_frame_collector_pkg.sv
// Shared definitions for the voice frame collector and its downstream mixer:
// collector FSM encoding, default frame geometry and wait timeout.
package voice_frame_collector_pkg;

    localparam int VFC_NUM_VOICES   = 32;
    localparam int VFC_SAMPLE_WIDTH = 16;
    localparam int VFC_FRAME_W      = VFC_NUM_VOICES * VFC_SAMPLE_WIDTH;
    localparam int VFC_TIMEOUT      = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_WAIT    = 2'd2,
        ST_PUBLISH = 2'd3
    } vfc_state_e;

endpackage

// File: rtl/voice_wait_timer.sv
// Loadable saturating wait counter; o_expired is high once the count reaches LIMIT.
module voice_wait_timer
    import voice_frame_collector_pkg::*;
#(
    parameter  int LIMIT = VFC_TIMEOUT,
    localparam int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count < CNT_W'(LIMIT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count >= CNT_W'(LIMIT));

endmodule

// File: rtl/voice_frame_collector.sv
// Polls a time-multiplexed voice generator once per frame and publishes a double-buffered
// packed frame. Optional per-voice muting is enabled with the VOICE_MUTE_EN macro.
module voice_frame_collector
    import voice_frame_collector_pkg::*;
#(
    parameter  int NUM_VOICES   = VFC_NUM_VOICES,
    parameter  int SAMPLE_WIDTH = VFC_SAMPLE_WIDTH,
    parameter  int TIMEOUT      = VFC_TIMEOUT,
    localparam int IDX_W        = $clog2(NUM_VOICES),
    localparam int FRAME_W      = NUM_VOICES * SAMPLE_WIDTH,
    localparam int CNT_W        = $clog2(TIMEOUT + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_generate_next,
    input  logic                           i_voice_sample_ready,
    input  logic signed [SAMPLE_WIDTH-1:0] i_voice_sample,
`ifdef VOICE_MUTE_EN
    input  logic [NUM_VOICES-1:0]          i_mute_mask,
`endif
    output logic [IDX_W-1:0]               o_voice_index,
    output logic                           o_voice_request,
    output logic [FRAME_W-1:0]             o_samples,
    output logic                           o_samples_ready,
    output logic                           o_overrun,
    output logic                           o_timeout_seen
);

    vfc_state_e         r_state;
    vfc_state_e         w_next_state;
    logic [IDX_W-1:0]   r_idx;
    logic [FRAME_W-1:0] r_shadow;
    logic [FRAME_W-1:0] r_samples;
    logic               r_samples_ready;
    logic               r_overrun;
    logic               r_timeout_seen;

    logic w_muted;
    logic w_expired;
    logic w_start;
    logic w_got;
    logic w_tmo;
    logic w_skip;
    logic w_advance;
    logic w_last;

`ifdef VOICE_MUTE_EN
    logic [NUM_VOICES-1:0] r_mute;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mute <= '0;
        end else if (w_start) begin
            r_mute <= i_mute_mask;
        end
    end

    assign w_muted = r_mute[r_idx];
`else
    assign w_muted = 1'b0;
`endif

    // A real sample takes priority over an expiry landing in the same cycle.
    assign w_start   = (r_state == ST_IDLE) && i_generate_next;
    assign w_got     = (r_state == ST_WAIT) && i_voice_sample_ready;
    assign w_tmo     = (r_state == ST_WAIT) && !i_voice_sample_ready && w_expired;
    assign w_skip    = (r_state == ST_REQUEST) && w_muted;
    assign w_advance = w_got || w_tmo || w_skip;
    assign w_last    = (r_idx == IDX_W'(NUM_VOICES - 1));

    voice_wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (r_state == ST_REQUEST),
        .i_load     (1'b0),
        .i_load_val ({CNT_W{1'b0}}),
        .i_en       (r_state == ST_WAIT),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_generate_next) w_next_state = ST_REQUEST;
            end
            ST_REQUEST: begin
                if (w_muted) w_next_state = w_last ? ST_PUBLISH : ST_REQUEST;
                else         w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_got || w_tmo) w_next_state = w_last ? ST_PUBLISH : ST_REQUEST;
            end
            ST_PUBLISH: begin
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx           <= '0;
            r_shadow        <= '0;
            r_samples       <= '0;
            r_samples_ready <= 1'b0;
            r_overrun       <= 1'b0;
            r_timeout_seen  <= 1'b0;
        end else begin
            if (w_start) r_idx <= '0;
            if (w_advance) begin
                r_shadow[r_idx*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= w_got ? i_voice_sample : '0;
                if (!w_last) r_idx <= r_idx + 1'b1;
            end
            if (w_tmo) r_timeout_seen <= 1'b1;
            if (i_generate_next && (r_state != ST_IDLE)) r_overrun <= 1'b1;
            // Frame copy and its ready pulse land on the same edge.
            if (r_state == ST_PUBLISH) r_samples <= r_shadow;
            r_samples_ready <= (r_state == ST_PUBLISH);
        end
    end

    assign o_voice_index   = r_idx;
    assign o_voice_request = (r_state == ST_REQUEST) && !w_muted;
    assign o_samples       = r_samples;
    assign o_samples_ready = r_samples_ready;
    assign o_overrun       = r_overrun;
    assign o_timeout_seen  = r_timeout_seen;

endmodule

// File: tb/tb_voice_frame_collector.sv
// Directed bench for voice_frame_collector with a behavioural voice generator model.
module tb_voice_frame_collector;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         i_generate_next = 1'b0;
    logic         i_voice_sample_ready = 1'b0;
    logic [15:0]  i_voice_sample = 16'h0;
    logic [4:0]   o_voice_index;
    logic         o_voice_request;
    logic [511:0] o_samples;
    logic         o_samples_ready;
    logic         o_overrun;
    logic         o_timeout_seen;
`ifdef VOICE_MUTE_EN
    logic [31:0]  mute_mask = 32'h0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int g_cyc   = 0;
    int req_cnt = 0;
    int rdy_cnt = 0;

    // Generator model configuration
    logic [15:0] gen_base    = 16'h0;
    bit          gen_step    = 1'b0;
    int          silent_from = 32;
    int          late_voice  = 99;
    int          late_delay  = 1;
    int          pend_cnt    = 0;
    int          pend_idx    = 0;

    bit           tear_en = 1'b0;
    logic [511:0] prev_samples = '0;
    logic [511:0] all7fff;
    logic [511:0] all8000;

    voice_frame_collector dut (
        .clk                  (clk),
        .reset                (reset),
        .i_generate_next      (i_generate_next),
        .i_voice_sample_ready (i_voice_sample_ready),
        .i_voice_sample       (i_voice_sample),
`ifdef VOICE_MUTE_EN
        .i_mute_mask          (mute_mask),
`endif
        .o_voice_index        (o_voice_index),
        .o_voice_request      (o_voice_request),
        .o_samples            (o_samples),
        .o_samples_ready      (o_samples_ready),
        .o_overrun            (o_overrun),
        .o_timeout_seen       (o_timeout_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] gen_val(input int k);
        return gen_base + (gen_step ? 16'(k) : 16'd0);
    endfunction

    function automatic logic [511:0] mk_frame(input logic [15:0] base, input bit step);
        logic [511:0] f;
        for (int k = 0; k < 32; k++) f[k*16 +: 16] = base + (step ? 16'(k) : 16'd0);
        return f;
    endfunction

    // Observe mid-cycle: count pulses, latch generator requests, watch for torn frames.
    always @(negedge clk) begin
        if (o_voice_request) begin
            req_cnt++;
            if (int'(o_voice_index) < silent_from) begin
                pend_idx = int'(o_voice_index);
                pend_cnt = (int'(o_voice_index) == late_voice) ? late_delay : 1;
            end
        end
        if (o_samples_ready) rdy_cnt++;
        if (tear_en && (o_samples !== prev_samples)) begin
            check("tear_pub", o_samples_ready, 1);
            check("tear_val", o_samples, all8000);
        end
        prev_samples = o_samples;
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        i_voice_sample_ready = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                i_voice_sample_ready = 1'b1;
                i_voice_sample       = gen_val(pend_idx);
            end
        end
    end

    task automatic pulse_gen();
        @(posedge clk); #1;
        i_generate_next = 1'b1;
        g_cyc = cyc;
        @(posedge clk); #1;
        i_generate_next = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic wait_ready(input int bound, output int lat);
        lat = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (o_samples_ready) begin
                lat = cyc - g_cyc;
                break;
            end
        end
        if (lat < 0) check("ready_timeout", 0, 1);
    endtask

    task automatic wait_index(input int idx, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (int'(o_voice_index) == idx) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("index_timeout", 0, 1);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_idx"},  o_voice_index, 0);
        check({pfx, "_req"},  o_voice_request, 0);
        check({pfx, "_smp"},  o_samples, 0);
        check({pfx, "_rdy"},  o_samples_ready, 0);
        check({pfx, "_ovr"},  o_overrun, 0);
        check({pfx, "_tmo"},  o_timeout_seen, 0);
    endtask

    initial begin
        int lat;
        int r0;
        int d0;
        logic [511:0] exp;

        all7fff = {32{16'h7FFF}};
        all8000 = {32{16'h8000}};

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_all_zero("rst");

        // Nominal frame, generator answers one cycle after each request
        gen_base = 16'h0100; gen_step = 1'b1; silent_from = 32;
        r0 = req_cnt; d0 = rdy_cnt;
        pulse_gen();
        wait_ready(300, lat);
        check("nom_lat", lat, 66);
        check("nom_smp", o_samples, mk_frame(16'h0100, 1'b1));
        repeat (10) @(negedge clk);
        check("nom_reqs", req_cnt - r0, 32);
        check("nom_rdys", rdy_cnt - d0, 1);
        check("nom_ovr", o_overrun, 0);
        check("nom_tmo", o_timeout_seen, 0);

        // Voice 31 never answers
        silent_from = 31;
        d0 = rdy_cnt;
        pulse_gen();
        wait_ready(1000, lat);
        check("tmo_lat", lat, 321);
        exp = mk_frame(16'h0100, 1'b1);
        exp[31*16 +: 16] = 16'h0000;
        check("tmo_smp", o_samples, exp);
        check("tmo_flag", o_timeout_seen, 1);
        repeat (10) @(negedge clk);
        check("tmo_rdys", rdy_cnt - d0, 1);

        // Second start request mid-frame
        gen_base = 16'h0200; silent_from = 32;
        r0 = req_cnt; d0 = rdy_cnt;
        pulse_gen();
        wait_index(10, 100);
        pulse_gen();
        wait_ready(300, lat);
        check("ovr_smp", o_samples, mk_frame(16'h0200, 1'b1));
        check("ovr_flag", o_overrun, 1);
        repeat (100) @(negedge clk);
        check("ovr_rdys", rdy_cnt - d0, 1);
        check("ovr_reqs", req_cnt - r0, 32);

        // Reset mid-frame, then a clean frame where voice 31 answers on the expiry cycle
        gen_base = 16'h0300;
        pulse_gen();
        wait_index(17, 100);
        do_reset();
        check_all_zero("midrst");
        repeat (5) @(negedge clk);
        late_voice = 31; late_delay = 256;
        pulse_gen();
        wait_ready(1000, lat);
        check("race_lat", lat, 321);
        check("race_smp", o_samples, mk_frame(16'h0300, 1'b1));
        check("race_tmo", o_timeout_seen, 0);
        check("race_ovr", o_overrun, 0);
        late_voice = 99; late_delay = 1;
        repeat (5) @(negedge clk);

        // Frame of 0x7FFF with a start request during the publish cycle
        gen_base = 16'h7FFF; gen_step = 1'b0;
        r0 = req_cnt; d0 = rdy_cnt;
        pulse_gen();
        while (cyc < g_cyc + 65) begin
            @(posedge clk); #1;
        end
        i_generate_next = 1'b1;
        @(posedge clk); #1;
        i_generate_next = 1'b0;
        check("pub_rdy", o_samples_ready, 1);
        check("pub_smp", o_samples, all7fff);
        repeat (80) @(negedge clk);
        check("pub_reqs", req_cnt - r0, 32);
        check("pub_rdys", rdy_cnt - d0, 1);
        check("pub_ovr", o_overrun, 1);

        // Next frame of 0x8000 must replace the old one atomically
        gen_base = 16'h8000;
        tear_en = 1'b1;
        pulse_gen();
        wait_ready(300, lat);
        check("tear_lat", lat, 66);
        check("tear_smp", o_samples, all8000);
        repeat (3) @(negedge clk);
        tear_en = 1'b0;

`ifdef VOICE_MUTE_EN
        // Upper half muted
        gen_base = 16'h0400; gen_step = 1'b1;
        mute_mask = 32'hFFFF_0000;
        r0 = req_cnt;
        pulse_gen();
        wait_ready(300, lat);
        exp = mk_frame(16'h0400, 1'b1);
        exp[511:256] = '0;
        check("mute_lat", lat, 50);
        check("mute_smp", o_samples, exp);
        repeat (5) @(negedge clk);
        check("mute_reqs", req_cnt - r0, 16);
        mute_mask = 32'h0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
